ntt_stream_io: RTL and testbench
================================

# ntt_stream_io

Stream-side sequencer placed directly upstream and downstream of the `ntt` top. It turns a 32-bit valid/ready coefficient stream into full 257-lane memory rows and writes them through the core's direct-write port. It then launches the transform and waits for the core's `done`. Finally it reads the result rows back through the direct-read port and streams them out one coefficient at a time.

## Interface
- `WIDTH`, 32, coefficient width.
- `SIZE`, 257, lanes per memory row (one word per bank).
- `READ_LATENCY`, 2, cycles from `ntt_mem_read` assertion until `ntt_dout` is valid.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset); deassertion is synchronous to `clk`.
- `cmd_start`  input  1  one-cycle command pulse; honoured only in IDLE.
- `cmd_mod_idx`  input  6  modulus index, latched at `cmd_start`.
- `cmd_rows_m1`  input  8  rows to process minus 1 (0..255 → 1..256 rows), latched at `cmd_start`.
- `busy`  output  1  high in every state except IDLE.
- `cmd_done`  output  1  one-cycle pulse after the last output word handshake.
- `s_data`  input  WIDTH  input coefficient.
- `s_valid`  input  1  input valid.
- `s_ready`  output  1  input ready.
- `m_data`  output  WIDTH  output coefficient.
- `m_valid`  output  1  output valid.
- `m_ready`  input  1  output ready.
- `m_last`  output  1  high with the final word of the final row.
- `ntt_start`  output  1  one-cycle start pulse to the core.
- `ntt_mod_idx`  output  6  latched `cmd_mod_idx`, stable from command until IDLE.
- `ntt_mem_write`  output  1  direct row write strobe.
- `ntt_mem_read`  output  1  direct row read enable.
- `ntt_mem_addr`  output  8*SIZE  row index replicated into every lane's 8-bit field.
- `ntt_din`  output  WIDTH*SIZE  assembled row; lane j at bits [WIDTH*(j+1)-1 : WIDTH*j].
- `ntt_dout`  input  WIDTH*SIZE  row read data.
- `ntt_done`  input  1  core completion (level or pulse; sampled only in WAIT).

## Operation
- States: IDLE → LOAD → WRITE ↔ LOAD … → KICK → WAIT → READ → STREAM ↔ READ … → FINISH → IDLE.
- **IDLE**
  - All strobes are 0.
  - When `cmd_start`=1, latch `cmd_mod_idx` and `cmd_rows_m1`, clear the row counter, and go to LOAD.
  - `cmd_start` in any other state is ignored.
- **LOAD**
  - `s_ready`=1.
  - Each handshake writes `s_data` into lane `lane_cnt` of the row buffer and increments `lane_cnt` (0..SIZE-1).
  - The handshake with `lane_cnt`=SIZE-1 wraps `lane_cnt` to 0 and moves to WRITE.
- **WRITE** (1 cycle)
  - `s_ready`=0.
  - `ntt_mem_write`=1, `ntt_din`=buffer, `ntt_mem_addr`={SIZE{row}}.
  - If row = rows_m1, clear the row counter and go to KICK; otherwise increment row and return to LOAD.
- **KICK** (1 cycle): `ntt_start`=1.
- **WAIT**
  - `ntt_done` is ignored during the KICK cycle.
  - The first cycle with `ntt_done`=1 in WAIT moves to READ.
- **READ** (READ_LATENCY+1 cycles)
  - `ntt_mem_read`=1 and `ntt_mem_addr`={SIZE{row}}, both held constant.
  - On the final cycle, `ntt_dout` is captured into the output buffer; go to STREAM.
- **STREAM**
  - `m_valid`=1, `m_data`=buffer lane `lane_cnt`.
  - On handshake, `lane_cnt` advances. After the lane SIZE-1 handshake: if row = rows_m1 go to FINISH, else increment row and go to READ.
  - There is no read-ahead; the next row read starts only after the current row is fully drained.
- **FINISH** (1 cycle): `cmd_done`=1, then IDLE.
- Counters: `lane_cnt` is 9 bits and wraps at SIZE-1 to 0. `row` is 8 bits and never exceeds rows_m1.
- Asynchronous reset, at any time including mid-LOAD, mid-WAIT or mid-STREAM:
  - state → IDLE; counters and latched fields → 0.
  - Every output → 0.
  - Partial row contents are discarded.

## Timing
- Reset values: `busy`, `cmd_done`, `s_ready`, `m_valid`, `m_last`, `ntt_start`, `ntt_mem_write`, `ntt_mem_read` = 0; `m_data`, `ntt_din`, `ntt_mem_addr`, `ntt_mod_idx` = 0.
- `cmd_start` in cycle C: `busy`=1 and `s_ready`=1 from C+1.
- Input throughput: SIZE words per SIZE+1 cycles (one bubble per row for WRITE).
- The KICK cycle immediately follows the last WRITE cycle.
- READ entered at cycle R: first `m_valid`=1 at cycle R+READ_LATENCY+1.
- `m_data` and `m_last` are registered and held stable while `m_valid`=1 and `m_ready`=0.
- `cmd_done` is asserted the cycle after the final handshake; `busy` falls in the same cycle as `cmd_done` returns to 0.

## Test plan
- **Single row:** `cmd_rows_m1`=0, `s_data`=k for k=0..256, `s_valid` always 1.
  - Exactly one `ntt_mem_write` pulse.
  - `ntt_din` lane j = j; `ntt_mem_addr` = all 0x00.
  - `ntt_start` is pulsed on the next cycle.
- **Full round trip:** `cmd_rows_m1`=3 against a behavioural core model (memory, READ_LATENCY=2, done 50 cycles after start, identity transform).
  - Output stream = input stream, 1028 words.
  - `m_last` only on word 1027.
  - `cmd_done` pulses once.
- **Backpressure:** random `s_valid` and random `m_ready` at 30%.
  - No word is lost or duplicated.
  - `m_data` is stable under stall.
  - `ntt_mem_read` is held exactly 3 cycles per row.
- **Done handling:** `ntt_done` held 1 before `cmd_start` and during KICK; no READ may start before the core's real done edge after KICK.
- **Reset mid-operation:** assert `reset`=0 after 100 input words.
  - All outputs are 0 immediately (asynchronously).
  - After release, a new command with `cmd_rows_m1`=0 completes correctly with row address 0.
- **Ignored command:** `cmd_start` pulsed during STREAM with a different `cmd_mod_idx`; `ntt_mod_idx` and the row count are unchanged.

Source files
------------

// File: rtl/ntt_stream_io_if.sv
// Coefficient stream bundle: input stream (s_*) toward the sequencer and output stream (m_*) away from it.
// Pure wiring, no latency; valid/ready on both directions.
// The slave modport is the sequencer's view, the master modport is the producer/consumer view.
interface ntt_stream_io_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/ntt_stream_io.sv
// Packs a coefficient stream into NTT memory rows, runs the core, and unpacks the result rows back to a stream.
// Latency: one WRITE bubble per input row; READ_LATENCY+1 cycles per output row before its first word.
// Backpressure: s_ready only in LOAD; m_data/m_last hold under m_ready=0; no read-ahead between rows.
module ntt_stream_io #(
    parameter int WIDTH        = 32,
    parameter int SIZE         = 257,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_start,
    input  logic [5:0]              cmd_mod_idx,
    input  logic [7:0]              cmd_rows_m1,
    output logic                    busy,
    output logic                    cmd_done,
    ntt_stream_io_if.slave          strm,
    output logic                    ntt_start,
    output logic [5:0]              ntt_mod_idx,
    output logic                    ntt_mem_write,
    output logic                    ntt_mem_read,
    output logic [8*SIZE-1:0]       ntt_mem_addr,
    output logic [WIDTH*SIZE-1:0]   ntt_din,
    input  logic [WIDTH*SIZE-1:0]   ntt_dout,
    input  logic                    ntt_done
);

    localparam int              ROW_W    = WIDTH * SIZE;
    localparam int              RD_W     = $clog2(READ_LATENCY + 1);
    localparam logic [8:0]      LANE_MAX = 9'(SIZE - 1);
    localparam logic [RD_W-1:0] RD_LAST  = RD_W'(READ_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_KICK,
        ST_WAIT,
        ST_READ,
        ST_STREAM,
        ST_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      lane_cnt_q, lane_cnt_d;
    logic [7:0]      row_q, row_d;
    logic [7:0]      rows_m1_q, rows_m1_d;
    logic [5:0]      mod_idx_q, mod_idx_d;
    logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ROW_W-1:0] ibuf_q, ibuf_d;
    logic [ROW_W-1:0] obuf_q, obuf_d;

    logic last_lane;
    logic last_row;

    assign last_lane = (lane_cnt_q == LANE_MAX);
    assign last_row  = (row_q == rows_m1_q);

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        row_d      = row_q;
        rows_m1_d  = rows_m1_q;
        mod_idx_d  = mod_idx_q;
        rd_cnt_d   = rd_cnt_q;
        ibuf_d     = ibuf_q;
        obuf_d     = obuf_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    mod_idx_d  = cmd_mod_idx;
                    rows_m1_d  = cmd_rows_m1;
                    row_d      = '0;
                    lane_cnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (strm.s_valid) begin
                    // Shift in at the top: after SIZE words the first word sits in lane 0.
                    ibuf_d = {strm.s_data, ibuf_q[ROW_W-1:WIDTH]};
                    if (last_lane) begin
                        lane_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 9'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (last_row) begin
                    row_d   = '0;
                    state_d = ST_KICK;
                end else begin
                    row_d   = row_q + 8'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_KICK: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ntt_done) begin
                    rd_cnt_d = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_cnt_q == RD_LAST) begin
                    obuf_d   = ntt_dout;
                    rd_cnt_d = '0;
                    state_d  = ST_STREAM;
                end else begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                end
            end
            ST_STREAM: begin
                if (strm.m_ready) begin
                    // Lane 0 of the buffer is the registered output word; shifting exposes the next lane.
                    obuf_d = {{WIDTH{1'b0}}, obuf_q[ROW_W-1:WIDTH]};
                    if (last_lane) begin
                        lane_cnt_d = '0;
                        if (last_row) begin
                            state_d = ST_FINISH;
                        end else begin
                            row_d   = row_q + 8'd1;
                            state_d = ST_READ;
                        end
                    end else begin
                        lane_cnt_d = lane_cnt_q + 9'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lane_cnt_q <= '0;
            row_q      <= '0;
            rows_m1_q  <= '0;
            mod_idx_q  <= '0;
            rd_cnt_q   <= '0;
            ibuf_q     <= '0;
            obuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            row_q      <= row_d;
            rows_m1_q  <= rows_m1_d;
            mod_idx_q  <= mod_idx_d;
            rd_cnt_q   <= rd_cnt_d;
            ibuf_q     <= ibuf_d;
            obuf_q     <= obuf_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign cmd_done      = (state_q == ST_FINISH);
    assign strm.s_ready  = (state_q == ST_LOAD);
    assign strm.m_valid  = (state_q == ST_STREAM);
    assign strm.m_data   = obuf_q[WIDTH-1:0];
    assign strm.m_last   = (state_q == ST_STREAM) && last_lane && last_row;
    assign ntt_start     = (state_q == ST_KICK);
    assign ntt_mod_idx   = mod_idx_q;
    assign ntt_mem_write = (state_q == ST_WRITE);
    assign ntt_mem_read  = (state_q == ST_READ);
    assign ntt_mem_addr  = (ntt_mem_write || ntt_mem_read) ? {SIZE{row_q}} : '0;
    assign ntt_din       = ibuf_q;

endmodule

// File: tb/tb_ntt_stream_io.sv
// Bench for ntt_stream_io against a behavioural core (row memory, 2-cycle read, done 50 cycles after start, identity).
module tb_ntt_stream_io;

    localparam int WIDTH = 32;
    localparam int SIZE  = 257;
    localparam int ROW_W = WIDTH * SIZE;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             l;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              cmd_start;
    logic [5:0]        cmd_mod_idx;
    logic [7:0]        cmd_rows_m1;
    logic              busy;
    logic              cmd_done;
    logic              ntt_start;
    logic [5:0]        ntt_mod_idx;
    logic              ntt_mem_write;
    logic              ntt_mem_read;
    logic [8*SIZE-1:0] ntt_mem_addr;
    logic [ROW_W-1:0]  ntt_din;
    logic [ROW_W-1:0]  ntt_dout;
    logic              core_done = 1'b1;

    ntt_stream_io_if #(.WIDTH(WIDTH)) bus ();

    ntt_stream_io #(.WIDTH(WIDTH), .SIZE(SIZE), .READ_LATENCY(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_start    (cmd_start),
        .cmd_mod_idx  (cmd_mod_idx),
        .cmd_rows_m1  (cmd_rows_m1),
        .busy         (busy),
        .cmd_done     (cmd_done),
        .strm         (bus.slave),
        .ntt_start    (ntt_start),
        .ntt_mod_idx  (ntt_mod_idx),
        .ntt_mem_write(ntt_mem_write),
        .ntt_mem_read (ntt_mem_read),
        .ntt_mem_addr (ntt_mem_addr),
        .ntt_din      (ntt_din),
        .ntt_dout     (ntt_dout),
        .ntt_done     (core_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural core model
    logic [ROW_W-1:0] mem [0:3];
    logic [ROW_W-1:0] rd_p1, rd_p2;
    int               dcnt = 0;
    assign ntt_dout = rd_p2;

    always @(posedge clk) begin
        if (ntt_mem_write) mem[ntt_mem_addr[1:0]] <= ntt_din;
        if (ntt_mem_read)  rd_p1 <= mem[ntt_mem_addr[1:0]];
        rd_p2 <= rd_p1;
        if (ntt_start) begin
            core_done <= 1'b0;
            dcnt      <= 50;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) core_done <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard and monitors
    exp_t             exp_q[$];
    int               cyc = 0;
    int               wr_cnt = 0, wr_cyc = 0, start_cnt = 0, start_cyc = 0, done_cnt = 0, rd_run = 0;
    bit               wait_read = 0, prev_stall = 0, bp_mode = 0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;
    logic [ROW_W-1:0] last_din;
    logic [8*SIZE-1:0] last_addr;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = bp_mode ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 0;
            rd_run     = 0;
            wait_read  = 0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {32'd0, bus.m_data}, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_data", {32'd0, bus.m_data}, {32'd0, e.d});
                    chk("m_last", {63'd0, bus.m_last}, {63'd0, e.l});
                end
            end
            if (prev_stall && bus.m_valid) begin
                chk("m_data_stable", {32'd0, bus.m_data}, {32'd0, prev_data});
                chk("m_last_stable", {63'd0, bus.m_last}, {63'd0, prev_last});
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;

            if (ntt_mem_read) begin
                rd_run++;
                if (wait_read) begin
                    wait_read = 0;
                    chk("read_after_done", {63'd0, (cyc - start_cyc) >= 50}, 64'd1);
                end
            end else if (rd_run != 0) begin
                chk("read_run_len", rd_run, 3);
                rd_run = 0;
            end
            if (ntt_mem_write) begin
                wr_cnt++;
                wr_cyc    = cyc;
                last_din  = ntt_din;
                last_addr = ntt_mem_addr;
            end
            if (ntt_start) begin
                start_cnt++;
                start_cyc = cyc;
                wait_read = 1;
                chk("start_after_write", cyc, wr_cyc + 1);
            end
            if (cmd_done) done_cnt++;
        end
    end

    // Stimulus
    task automatic check_zero(input string tag);
        chk({tag, "_busy"},     {63'd0, busy},          64'd0);
        chk({tag, "_cmd_done"}, {63'd0, cmd_done},      64'd0);
        chk({tag, "_s_ready"},  {63'd0, bus.s_ready},   64'd0);
        chk({tag, "_m_valid"},  {63'd0, bus.m_valid},   64'd0);
        chk({tag, "_m_last"},   {63'd0, bus.m_last},    64'd0);
        chk({tag, "_start"},    {63'd0, ntt_start},     64'd0);
        chk({tag, "_write"},    {63'd0, ntt_mem_write}, 64'd0);
        chk({tag, "_read"},     {63'd0, ntt_mem_read},  64'd0);
        chk({tag, "_m_data"},   {32'd0, bus.m_data},    64'd0);
        chk({tag, "_mod_idx"},  {58'd0, ntt_mod_idx},   64'd0);
        chk({tag, "_din_zero"}, {63'd0, ntt_din == '0}, 64'd1);
        chk({tag, "_addr_zero"}, {63'd0, ntt_mem_addr == '0}, 64'd1);
    endtask

    task automatic start_cmd(input logic [7:0] rm1, input logic [5:0] mi);
        @(posedge clk);
        #1;
        cmd_start   = 1'b1;
        cmd_rows_m1 = rm1;
        cmd_mod_idx = mi;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        chk("busy_after_cmd", {63'd0, busy}, 64'd1);
        chk("s_ready_after_cmd", {63'd0, bus.s_ready}, 64'd1);
    endtask

    task automatic feed(input int n, input int base, input bit bp, input int last_idx);
        int  k = 0;
        int  guard = 0;
        bit  hs;
        exp_t e;
        while (k < n && guard < 20000) begin
            bus.s_valid = bp ? ($urandom_range(0, 9) < 7) : 1'b1;
            bus.s_data  = WIDTH'(base + k);
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                e.d = WIDTH'(base + k);
                e.l = (k == last_idx);
                exp_q.push_back(e);
                k++;
            end
            guard++;
        end
        bus.s_valid = 1'b0;
        chk("feed_words", k, n);
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_done && t < 10000);
        chk(nm, {63'd0, cmd_done}, 64'd1);
        @(negedge clk);
        chk({nm, "_busy_low"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_row(input string nm, input int base);
        int bad = 0;
        for (int j = 0; j < SIZE; j++)
            if (last_din[j*WIDTH +: WIDTH] !== WIDTH'(base + j)) bad++;
        chk(nm, bad, 0);
    endtask

    initial begin
        reset       = 1'b0;
        cmd_start   = 1'b0;
        cmd_mod_idx = '0;
        cmd_rows_m1 = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #3;
        check_zero("rst");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Single row, no backpressure; core done already high before the command
        start_cmd(8'd0, 6'd5);
        feed(SIZE, 0, 1'b0, SIZE - 1);
        wait_done("single_done");
        chk("single_wr_cnt", wr_cnt, 1);
        chk("single_addr_zero", {63'd0, last_addr == '0}, 64'd1);
        check_row("single_din_lanes", 0);
        chk("single_start_cnt", start_cnt, 1);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_q_empty", exp_q.size(), 0);
        chk("single_mod_idx", {58'd0, ntt_mod_idx}, 64'd5);

        // Four rows with random backpressure on both sides; stray command during STREAM
        bp_mode = 1;
        start_cmd(8'd3, 6'd9);
        feed(4 * SIZE, 32'h1000, 1'b1, 4 * SIZE - 1);
        begin
            int t = 0;
            while (!bus.m_valid && t < 5000) begin
                @(negedge clk);
                t++;
            end
            chk("stream_reached", {63'd0, bus.m_valid}, 64'd1);
        end
        @(posedge clk);
        #1;
        cmd_start   = 1'b1;
        cmd_mod_idx = 6'h2A;
        cmd_rows_m1 = 8'd0;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        chk("ignored_cmd_mod_idx", {58'd0, ntt_mod_idx}, 64'd9);
        chk("ignored_cmd_busy", {63'd0, busy}, 64'd1);
        wait_done("multi_done");
        chk("multi_wr_cnt", wr_cnt, 5);
        chk("multi_addr_row3", {56'd0, last_addr[7:0]}, 64'd3);
        chk("multi_done_cnt", done_cnt, 2);
        chk("multi_q_empty", exp_q.size(), 0);

        // Reset in the middle of loading
        bp_mode = 0;
        start_cmd(8'd1, 6'd3);
        feed(100, 32'h3000, 1'b0, -1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        start_cmd(8'd0, 6'd7);
        feed(SIZE, 32'h5000, 1'b0, SIZE - 1);
        wait_done("after_rst_done");
        chk("after_rst_wr_cnt", wr_cnt, 6);
        chk("after_rst_addr_zero", {63'd0, last_addr == '0}, 64'd1);
        check_row("after_rst_din_lanes", 32'h5000);
        chk("after_rst_done_cnt", done_cnt, 3);
        chk("after_rst_q_empty", exp_q.size(), 0);
        chk("after_rst_mod_idx", {58'd0, ntt_mod_idx}, 64'd7);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
